// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-masked writes and a
// self-clearing sequence that zeroes every entry after reset.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic [DATA_W/8-1:0]      wrMask,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]          mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0]   rd_q, rd_d;
    logic                       wr_en;
    logic [DATA_W-1:0]          wr_old;
    logic [DATA_W-1:0]          wr_merged;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    assign wr_en = write && !busy && (|wrMask)
                   && !((ZERO_REG != 0) && (wrAddr == '0));

    assign wr_old = mem_q[wrAddr];

    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < NB; b++) begin
            if (wrMask[b]) begin
                wr_merged[b*8 +: 8] = wrData[b*8 +: 8];
            end
        end
    end

    // Each port forwards the merged word on a same-edge hit when bypassing.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] word;

        assign ra = rdAddr[p*ADDR_W +: ADDR_W];

        always_comb begin
            word = mem_q[ra];
            if ((BYPASS != 0) && wr_en && (ra == wrAddr)) begin
                word = wr_merged;
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                word = '0;
            end
            if (busy) begin
                word = '0;
            end
        end

        assign rd_d[p*DATA_W +: DATA_W] = word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd_q      <= rd_d;
        end
    end

    // Storage has no reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy) begin
                mem_q[clr_idx_q] <= '0;
            end else if (wr_en) begin
                mem_q[wrAddr] <= wr_merged;
            end
        end
    end

    assign rdData = rd_q;

endmodule
